reg_file_mp: RTL

REG_FILE_MP -- requirements
Module: reg_file_mp

---
 rtl/reg_file_pkg.sv | 13 +
 rtl/reg_scoreboard.sv | 54 +++++
 rtl/reg_file_mp.sv | 91 +++++++++
 3 files changed

// File: rtl/reg_file_pkg.sv
// Shared constants for the multi-port register file and its busy scoreboard.
//   XLEN_DEFAULT  : default data width in bits
//   NREGS_DEFAULT : default register count (power of two)
//   NRD_DEFAULT   : default number of read ports
//   ZERO_REG      : index of the hardwired-zero register
package reg_file_pkg;

    localparam int unsigned XLEN_DEFAULT  = 64;
    localparam int unsigned NREGS_DEFAULT = 32;
    localparam int unsigned NRD_DEFAULT   = 2;
    localparam int unsigned ZERO_REG      = 0;

endpackage : reg_file_pkg

// File: rtl/reg_scoreboard.sv
// Pending-write (busy) tracker for the register file.
// Ports:
//   clk, reset_n        : clock, asynchronous active-low reset
//   wr_en, wr_addr      : completed write, clears the destination's busy bit
//   alloc_en, alloc_addr: new producer, sets the destination's busy bit
//   flush               : clears every busy bit, same-cycle alloc is ignored
//   busy_vec            : registered busy bits, bit 0 always 0
module reg_scoreboard
    import reg_file_pkg::*;
#(
    parameter  int unsigned NREGS = NREGS_DEFAULT,
    localparam int unsigned AW    = $clog2(NREGS)
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             wr_en,
    input  logic [AW-1:0]    wr_addr,
    input  logic             alloc_en,
    input  logic [AW-1:0]    alloc_addr,
    input  logic             flush,
    output logic [NREGS-1:0] busy_vec
);

    logic [NREGS-1:0] busy_q;
    logic [NREGS-1:0] busy_d;

    // Next busy state; alloc applied after the write clear so the newer producer wins.
    always_comb begin
        busy_d = busy_q;
        if (flush) begin
            busy_d = '0;
        end else begin
            if (wr_en) begin
                busy_d[wr_addr] = 1'b0;
            end
            if (alloc_en) begin
                busy_d[alloc_addr] = 1'b1;
            end
        end
        busy_d[ZERO_REG] = 1'b0;
    end

    // Busy state register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            busy_q <= '0;
        end else begin
            busy_q <= busy_d;
        end
    end

    assign busy_vec = busy_q;

endmodule : reg_scoreboard

// File: rtl/reg_file_mp.sv
// Multi-read-port register file with a hardwired-zero register and a
// per-register pending-write scoreboard.
// Ports:
//   clk, reset_n          : clock, asynchronous active-low reset
//   rd_addr  [NRD*AW]     : packed read addresses, port p in [p*AW +: AW]
//   rd_data  [NRD*XLEN]   : combinational read data, port p in [p*XLEN +: XLEN]
//   rd_busy  [NRD]        : busy bit of the register each port addresses
//   wr_en/wr_addr/wr_data : write port
//   alloc_en/alloc_addr   : marks a destination as pending
//   flush                 : clears all pending marks
//   busy_vec [NREGS]      : current busy bits
// Build option: define REG_FILE_MP_BYPASS_EN to forward same-cycle write
// data to matching read ports and force their busy flag low.
module reg_file_mp
    import reg_file_pkg::*;
#(
    parameter  int unsigned XLEN  = XLEN_DEFAULT,
    parameter  int unsigned NREGS = NREGS_DEFAULT,
    parameter  int unsigned NRD   = NRD_DEFAULT,
    localparam int unsigned AW    = $clog2(NREGS)
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic [NRD*AW-1:0]   rd_addr,
    output logic [NRD*XLEN-1:0] rd_data,
    output logic [NRD-1:0]      rd_busy,
    input  logic                wr_en,
    input  logic [AW-1:0]       wr_addr,
    input  logic [XLEN-1:0]     wr_data,
    input  logic                alloc_en,
    input  logic [AW-1:0]       alloc_addr,
    input  logic                flush,
    output logic [NREGS-1:0]    busy_vec
);

    logic [XLEN-1:0] regs [NREGS];
    logic [AW-1:0]   rd_idx [NRD];
    logic            wr_live;

    assign wr_live = wr_en && (wr_addr != AW'(ZERO_REG));

    // Storage; register 0 is only ever reset, so it reads as zero forever.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            regs <= '{default: '0};
        end else if (wr_live) begin
            regs[wr_addr] <= wr_data;
        end
    end

    reg_scoreboard #(
        .NREGS (NREGS)
    ) u_scoreboard (
        .clk        (clk),
        .reset_n    (reset_n),
        .wr_en      (wr_en),
        .wr_addr    (wr_addr),
        .alloc_en   (alloc_en),
        .alloc_addr (alloc_addr),
        .flush      (flush),
        .busy_vec   (busy_vec)
    );

    // Unpack read addresses.
    always_comb begin
        for (int p = 0; p < NRD; p++) begin
            rd_idx[p] = rd_addr[p*AW +: AW];
        end
    end

    // Read muxes; outputs held at zero while in reset.
    always_comb begin
        rd_data = '0;
        rd_busy = '0;
        for (int p = 0; p < NRD; p++) begin
            rd_data[p*XLEN +: XLEN] = regs[rd_idx[p]];
            rd_busy[p]              = busy_vec[rd_idx[p]];
`ifdef REG_FILE_MP_BYPASS_EN
            if (wr_live && (rd_idx[p] == wr_addr)) begin
                rd_data[p*XLEN +: XLEN] = wr_data;
                rd_busy[p]              = 1'b0;
            end
`endif
        end
        if (!reset_n) begin
            rd_data = '0;
            rd_busy = '0;
        end
    end

endmodule : reg_file_mp
